// File: rtl/fifo_n.sv
// fifo_n: parametrised DEPTH x WIDTH FIFO with guarded enq/deq/first methods and an occupancy count.
// Define FIFO_N_PIPELINE_EN to let an enqueue land in the slot vacated by a same-cycle dequeue when full.
module fifo_n #(
    parameter int WIDTH = 768,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_enq__ENA,
    input  logic [WIDTH-1:0] in_enq_v,
    output logic             in_enq__RDY,
    input  logic             out_deq__ENA,
    output logic             out_deq__RDY,
    output logic [WIDTH-1:0] out_first,
    output logic             out_first__RDY,
    output logic [CW-1:0]    count
);
    localparam int PW = $clog2(DEPTH);

    // Valid/ready: a method takes effect on a rising edge only when its __ENA and __RDY are both high
    // at that edge; __RDY never depends on the same method's __ENA.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             empty;
    logic             enq_fire;
    logic             deq_fire;
    logic [PW-1:0]    head_next;
    logic [PW-1:0]    tail_next;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

`ifdef FIFO_N_PIPELINE_EN
    // When full, a dequeue this cycle frees the head slot for the incoming word.
    assign in_enq__RDY = !full | out_deq__ENA;
`else
    assign in_enq__RDY = !full;
`endif

    assign out_deq__RDY   = !empty;
    assign out_first__RDY = !empty;
    assign out_first      = mem[head];
    assign count          = cnt;

    assign enq_fire = in_enq__ENA & in_enq__RDY;
    assign deq_fire = out_deq__ENA & out_deq__RDY;

    // Explicit wrap compare keeps non-power-of-two depths correct.
    assign head_next = (head == PW'(DEPTH - 1)) ? '0 : head + PW'(1);
    assign tail_next = (tail == PW'(DEPTH - 1)) ? '0 : tail + PW'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (enq_fire) tail <= tail_next;
            if (deq_fire) head <= head_next;
            if (enq_fire && !deq_fire) begin
                cnt <= cnt + CW'(1);
            end else if (deq_fire && !enq_fire) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Payload storage is not reset; it is only observable through out_first once count is nonzero.
    always_ff @(posedge CLK) begin
        if (enq_fire && !RST) begin
            mem[tail] <= in_enq_v;
        end
    end
endmodule

// File: tb/tb_fifo_n.sv
// tb_fifo_n: checks a DEPTH=4 and a DEPTH=3 fifo_n against queue-based reference models.
// Directed scenarios pin literal values; randomized traffic is checked every cycle.
module tb_fifo_n;
    localparam int W = 16;
`ifdef FIFO_N_PIPELINE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b1;

    logic         enq_ena_a = 1'b0, deq_ena_a = 1'b0;
    logic [W-1:0] enq_v_a = '0;
    logic         enq_rdy_a, deq_rdy_a, first_rdy_a;
    logic [W-1:0] first_a;
    logic [2:0]   count_a;

    logic         enq_ena_b = 1'b0, deq_ena_b = 1'b0;
    logic [W-1:0] enq_v_b = '0;
    logic         enq_rdy_b, deq_rdy_b, first_rdy_b;
    logic [W-1:0] first_b;
    logic [1:0]   count_b;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] b_recv[$];
    int           b_sent = 0;
    int           max_cnt_b = 0;

    fifo_n #(.WIDTH(W), .DEPTH(4)) u_dut_a (
        .CLK(CLK), .RST(RST),
        .in_enq__ENA(enq_ena_a), .in_enq_v(enq_v_a), .in_enq__RDY(enq_rdy_a),
        .out_deq__ENA(deq_ena_a), .out_deq__RDY(deq_rdy_a),
        .out_first(first_a), .out_first__RDY(first_rdy_a), .count(count_a)
    );

    fifo_n #(.WIDTH(W), .DEPTH(3)) u_dut_b (
        .CLK(CLK), .RST(RST),
        .in_enq__ENA(enq_ena_b), .in_enq_v(enq_v_b), .in_enq__RDY(enq_rdy_b),
        .out_deq__ENA(deq_ena_b), .out_deq__RDY(deq_rdy_b),
        .out_first(first_b), .out_first__RDY(first_rdy_b), .count(count_b)
    );

    // Clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference models: an enq is accepted unless the queue is full (or, pipelined, a deq accompanies it).
    always @(posedge CLK or posedge RST) begin
        bit fe, fd;
        if (RST) begin
            qa.delete();
            qb.delete();
        end else begin
            fd = deq_ena_a && (qa.size() != 0);
            fe = enq_ena_a && ((qa.size() != 4) || (PIPE && deq_ena_a));
            if (fd) void'(qa.pop_front());
            if (fe) qa.push_back(enq_v_a);

            fd = deq_ena_b && (qb.size() != 0);
            fe = enq_ena_b && ((qb.size() != 3) || (PIPE && deq_ena_b));
            if (fd) begin
                void'(qb.pop_front());
                b_recv.push_back(first_b);
            end
            if (fe) begin
                qb.push_back(enq_v_b);
                b_sent++;
            end
        end
    end

    // Scoreboard compare, sampled on the falling edge
    always @(negedge CLK) begin
        if (cmp_en && !RST) begin
            check("a_count", 32'(count_a), qa.size());
            check("a_deq_rdy", 32'(deq_rdy_a), 32'(qa.size() != 0));
            check("a_first_rdy", 32'(first_rdy_a), 32'(qa.size() != 0));
            check("a_enq_rdy", 32'(enq_rdy_a), 32'((qa.size() != 4) || (PIPE && deq_ena_a)));
            if (qa.size() != 0) check("a_first", 32'(first_a), 32'(qa[0]));
            check("b_count", 32'(count_b), qb.size());
            check("b_deq_rdy", 32'(deq_rdy_b), 32'(qb.size() != 0));
            check("b_enq_rdy", 32'(enq_rdy_b), 32'((qb.size() != 3) || (PIPE && deq_ena_b)));
            if (qb.size() != 0) check("b_first", 32'(first_b), 32'(qb[0]));
            if (int'(count_b) > max_cnt_b) max_cnt_b = int'(count_b);
        end
    end

    // Driver tasks: each starts and ends 1 time unit after a rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic enq_a(input logic [W-1:0] v);
        enq_ena_a = 1'b1;
        enq_v_a   = v;
        step();
        enq_ena_a = 1'b0;
    endtask

    task automatic deq_a(input logic [W-1:0] exp);
        check("a_deq_data", 32'(first_a), 32'(exp));
        deq_ena_a = 1'b1;
        step();
        deq_ena_a = 1'b0;
    endtask

    initial begin
        int budget;
        bit enq_bias;

        repeat (3) step();
        RST = 1'b0;
        cmp_en = 1'b1;
        step();
        check("reset_count", 32'(count_a), 32'd0);
        check("reset_enq_rdy", 32'(enq_rdy_a), 32'd1);
        check("reset_deq_rdy", 32'(deq_rdy_a), 32'd0);

        // Fill and drain in order
        enq_a(16'h11); enq_a(16'h22); enq_a(16'h33); enq_a(16'h44);
        check("fill_count", 32'(count_a), 32'd4);
        check("fill_enq_rdy", 32'(enq_rdy_a), 32'd0);
        check("fill_first", 32'(first_a), 32'h11);
        deq_a(16'h11); deq_a(16'h22); deq_a(16'h33); deq_a(16'h44);
        check("drain_count", 32'(count_a), 32'd0);

        // Enq + deq together while full
        enq_a(16'h11); enq_a(16'h22); enq_a(16'h33); enq_a(16'h44);
        enq_ena_a = 1'b1; enq_v_a = 16'h55; deq_ena_a = 1'b1;
        step();
        enq_ena_a = 1'b0; deq_ena_a = 1'b0;
        check("full_both_first", 32'(first_a), 32'h22);
        if (PIPE) begin
            check("full_both_count", 32'(count_a), 32'd4);
            deq_a(16'h22); deq_a(16'h33); deq_a(16'h44); deq_a(16'h55);
        end else begin
            check("full_both_count", 32'(count_a), 32'd3);
            deq_a(16'h22); deq_a(16'h33); deq_a(16'h44);
        end
        check("full_both_end_count", 32'(count_a), 32'd0);

        // Deq on empty, then enq with deq on empty
        deq_ena_a = 1'b1;
        step();
        check("empty_deq_count", 32'(count_a), 32'd0);
        check("empty_deq_rdy", 32'(deq_rdy_a), 32'd0);
        enq_ena_a = 1'b1; enq_v_a = 16'hAA;
        step();
        enq_ena_a = 1'b0; deq_ena_a = 1'b0;
        check("empty_enq_count", 32'(count_a), 32'd1);
        check("empty_enq_first", 32'(first_a), 32'hAA);
        deq_a(16'hAA);

        // Asynchronous reset between edges with two entries held
        enq_a(16'h01); enq_a(16'h02);
        check("pre_rst_count", 32'(count_a), 32'd2);
        #3;
        RST = 1'b1;
        #1;
        check("async_rst_count", 32'(count_a), 32'd0);
        check("async_rst_first_rdy", 32'(first_rdy_a), 32'd0);
        step();
        RST = 1'b0;
        enq_a(16'h77); enq_a(16'h88);
        deq_a(16'h77); deq_a(16'h88);

        // DEPTH=3 stream of 1..10 with random gaps
        budget = 0;
        while (b_recv.size() < 10 && budget < 400) begin
            enq_ena_b = (b_sent < 10) && ($urandom_range(0, 3) != 0);
            enq_v_b   = W'(b_sent + 1);
            deq_ena_b = ($urandom_range(0, 2) == 0);
            step();
            budget++;
        end
        enq_ena_b = 1'b0; deq_ena_b = 1'b0;
        check("b_stream_len", b_recv.size(), 32'd10);
        for (int i = 0; i < b_recv.size() && i < 10; i++) begin
            check("b_stream_data", 32'(b_recv[i]), i + 1);
        end
        check("b_max_count_le3", 32'(max_cnt_b <= 3), 32'd1);

        // Randomized traffic on DEPTH=4, alternating fill-biased and drain-biased phases
        for (int i = 0; i < 400; i++) begin
            if (i % 40 == 0) enq_bias = ~enq_bias;
            enq_ena_a = enq_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            deq_ena_a = enq_bias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            enq_v_a   = W'($urandom);
            step();
        end
        enq_ena_a = 1'b0; deq_ena_a = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_n.md
Name: fifo_n

Overview:
- Parametrised N-entry FIFO; successor to the single-element Fifo1 class.
- Same guarded-method interface: in_enq / out_deq / out_first, each with __RDY, and __ENA where applicable.
- Adds configurable WIDTH and DEPTH, same-cycle enq+deq, an occupancy count, and an optional pipelined full-bypass.
- Sits between producer and consumer modules in the generated design; used wherever a one-deep buffer throttles throughput.

Parameters:
- WIDTH, 768, payload bits per entry.
- DEPTH, 4, number of entries; legal range 2..256, need not be a power of two.
- CW, $clog2(DEPTH+1), width of the count output (derived; do not override).

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous reset, active-high.
- in_enq__ENA  input  1  enqueue request; ignored unless in_enq__RDY.
- in_enq_v  input  WIDTH  enqueue data.
- in_enq__RDY  output  1  enqueue permitted.
- out_deq__ENA  input  1  dequeue request; ignored unless out_deq__RDY.
- out_deq__RDY  output  1  dequeue permitted (not empty).
- out_first  output  WIDTH  head entry data.
- out_first__RDY  output  1  out_first valid (not empty).
- count  output  CW  current occupancy, 0..DEPTH.

Behaviour:
- Internal qualified enables:
  - enq_fire = in_enq__ENA & in_enq__RDY
  - deq_fire = out_deq__ENA & out_deq__RDY
  - Unqualified ENA has no effect on any state.
- Storage: DEPTH x WIDTH register array; no reset on data, or reset to 0 (either is acceptable; bench must not depend on it).
- State:
  - head pointer, range 0..DEPTH-1
  - tail pointer, range 0..DEPTH-1
  - count register, range 0..DEPTH
- Reset (RST high, asynchronous, immediate): head=0, tail=0, count=0.
  - Hence in_enq__RDY=1, out_deq__RDY=0, out_first__RDY=0, count=0.
  - Reset asserted mid-operation discards all contents; no enq/deq takes effect in a cycle where RST is high at the edge.
- Ready signals:
  - out_deq__RDY = out_first__RDY = (count != 0).
  - in_enq__RDY = (count != DEPTH) in the base build.
- out_first = mem[head]; combinational from registers, no input-to-output path.
- enq_fire: mem[tail] <= in_enq_v; tail <= (tail==DEPTH-1) ? 0 : tail+1.
- deq_fire: head <= (head==DEPTH-1) ? 0 : head+1.
- count update per cycle:
  - enq only: +1
  - deq only: -1
  - both or neither: unchanged
- Simultaneous enq+deq with 0 < count < DEPTH: both fire; count unchanged; order preserved.
- Empty: deq ignored; an enq that cycle is written; out_first valid the next cycle (latency 1).
- Full (count==DEPTH): enq ignored in the base build even if deq fires the same cycle.
- Wrap-around: explicit compare against DEPTH-1, so non-power-of-two depths are correct.
- Strict FIFO ordering at all times; no data loss, no duplication.

Optional Feature:
- Macro: FIFO_N_PIPELINE_EN.
- Defined:
  - in_enq__RDY = (count != DEPTH) | out_deq__ENA.
  - When full and enq+deq fire together, the new data is written into the slot vacated at head (tail==head when full); both pointers advance and count stays DEPTH.
  - Sustains one transfer per cycle at full occupancy.
  - Creates a combinational path out_deq__ENA -> in_enq__RDY.
- Undefined: in_enq__RDY depends only on count, with no combinational input-to-output paths.

Test Plan:
- Reset, then 4 enqs of 0x11,0x22,0x33,0x44 (DEPTH=4) -> count=4, in_enq__RDY=0, out_first=0x11; 4 deqs yield 0x11,0x22,0x33,0x44 in order and end at count=0.
- Fill to 4, assert enq 0x55 with deq (base build) -> deq fires and enq is ignored; count=3, out_first=0x22, 0x55 is never seen.
- Same stimulus with FIFO_N_PIPELINE_EN -> both fire; count=4, sequence continues 0x22,0x33,0x44,0x55.
- DEPTH=3, stream 10 items with random deq gaps -> output exactly 1..10 in order; pointers wrap at 2 -> 0; count never exceeds 3.
- Empty FIFO, deq asserted alone -> no state change, count=0, out_deq__RDY=0; enq 0xAA the same cycle -> out_first=0xAA next cycle.
- Count=2, assert RST asynchronously between clock edges -> count=0 and out_first__RDY=0 immediately; after release, the first enq 0x77 is the first item dequeued.
